// File: rtl/dvi_tmds_encoder_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder: control symbols,
// symbol/disparity widths, a ones counter and the control-symbol lookup.
package dvi_tmds_encoder_pkg;

    localparam int SYM_W = 10;
    localparam int CNT_W = 5;

    localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, d[i]};
        end
        return n;
    endfunction

    function automatic logic [SYM_W-1:0] ctrl_sym(input logic [1:0] c);
        logic [SYM_W-1:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            2'b11:   s = CTRL_11;
            default: s = CTRL_00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dvi_tmds_encoder_channel_enc.sv
// One TMDS channel: stage 1 transition-minimising q_m, stage 2 DC balancing
// with a signed running disparity that is cleared during blanking.
module tmds_channel_enc
    import dvi_tmds_encoder_pkg::*;
(
    input  logic             PixelClk,
    input  logic             aRst_n,
    input  logic [7:0]       data,
    input  logic             vde,
    input  logic [1:0]       ctrl,
    output logic [SYM_W-1:0] sym
);

    logic [3:0]              n1_d_s;
    logic                    use_xnor_s;
    logic [8:0]              q_m_s;
    logic [8:0]              q_m_r;
    logic                    vde_r;
    logic [1:0]              ctrl_r;
    logic [3:0]              n1_s;
    logic [3:0]              n0_s;
    logic signed [CNT_W-1:0] diff_s;
    logic signed [CNT_W-1:0] cnt_r;
    logic signed [CNT_W-1:0] cnt_nxt_s;
    logic [SYM_W-1:0]        sym_nxt_s;

    // Stage 1: XOR or XNOR chain chosen by the ones count of the input byte
    always_comb begin
        n1_d_s     = ones8(data);
        use_xnor_s = (n1_d_s > 4'd4) || ((n1_d_s == 4'd4) && (data[0] == 1'b0));
        q_m_s      = 9'd0;
        q_m_s[0]   = data[0];
        for (int i = 1; i < 8; i++) begin
            q_m_s[i] = q_m_s[i-1] ^ data[i] ^ use_xnor_s;
        end
        q_m_s[8]   = ~use_xnor_s;
    end

    // Stage 1 registers: q_m plus the matching VDE and control bits
    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            q_m_r  <= 9'd0;
            vde_r  <= 1'b0;
            ctrl_r <= 2'b00;
        end else begin
            q_m_r  <= q_m_s;
            vde_r  <= vde;
            ctrl_r <= ctrl;
        end
    end

    // Stage 2: pick inversion to steer the running disparity back toward zero
    always_comb begin
        n1_s      = ones8(q_m_r[7:0]);
        n0_s      = 4'd8 - n1_s;
        diff_s    = $signed({1'b0, n1_s}) - $signed({1'b0, n0_s});
        sym_nxt_s = CTRL_00;
        cnt_nxt_s = 5'sd0;
        if (!vde_r) begin
            sym_nxt_s = ctrl_sym(ctrl_r);
            cnt_nxt_s = 5'sd0;
        end else if ((cnt_r == 5'sd0) || (n1_s == n0_s)) begin
            sym_nxt_s = {~q_m_r[8], q_m_r[8], (q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0])};
            cnt_nxt_s = q_m_r[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
        end else if (((cnt_r > 5'sd0) && (n1_s > n0_s)) || ((cnt_r < 5'sd0) && (n0_s > n1_s))) begin
            sym_nxt_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            cnt_nxt_s = cnt_r + (q_m_r[8] ? 5'sd2 : 5'sd0) - diff_s;
        end else begin
            sym_nxt_s = {1'b0, q_m_r[8], q_m_r[7:0]};
            cnt_nxt_s = cnt_r + diff_s - (q_m_r[8] ? 5'sd0 : 5'sd2);
        end
    end

    // Stage 2 registers: output symbol and running disparity
    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            sym   <= CTRL_00;
            cnt_r <= 5'sd0;
        end else begin
            sym   <= sym_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder top: sync inversion, VDE alignment and three channel encoders.
// Optional colour-bar source enabled by macro TMDS_TEST_PATTERN_EN.
module dvi_tmds_encoder
    import dvi_tmds_encoder_pkg::*;
#(
    parameter int SYNC_INV  = 1,
    parameter int BAR_SHIFT = 7
) (
    input  logic             PixelClk,
    input  logic             aRst_n,
    input  logic [23:0]      vid_pData,
    input  logic             vid_pVDE,
    input  logic             vid_pHSync,
    input  logic             vid_pVSync,
    input  logic             pattern_en,
    output logic [SYM_W-1:0] tmds_ch0,
    output logic [SYM_W-1:0] tmds_ch1,
    output logic [SYM_W-1:0] tmds_ch2,
    output logic             tx_vde
);

    logic        hs_s;
    logic        vs_s;
    logic        vde_d1_r;
    logic [23:0] pix_s;

    assign hs_s = (SYNC_INV != 0) ? ~vid_pHSync : vid_pHSync;
    assign vs_s = (SYNC_INV != 0) ? ~vid_pVSync : vid_pVSync;

`ifdef TMDS_TEST_PATTERN_EN
    logic [BAR_SHIFT+2:0] px_cnt_r;
    logic [2:0]           bar_s;
    logic [23:0]          bar_pix_s;

    // Pixel counter restarts at the start of every active run
    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            px_cnt_r <= '0;
        end else if (vid_pVDE) begin
            px_cnt_r <= px_cnt_r + 1'b1;
        end else begin
            px_cnt_r <= '0;
        end
    end

    // Bar colours packed as {R, B, G}
    always_comb begin
        bar_s = px_cnt_r[BAR_SHIFT+2:BAR_SHIFT];
        case (bar_s)
            3'd0:    bar_pix_s = 24'hFFFFFF;
            3'd1:    bar_pix_s = 24'hFF00FF;
            3'd2:    bar_pix_s = 24'h00FFFF;
            3'd3:    bar_pix_s = 24'h0000FF;
            3'd4:    bar_pix_s = 24'hFFFF00;
            3'd5:    bar_pix_s = 24'hFF0000;
            3'd6:    bar_pix_s = 24'h00FF00;
            3'd7:    bar_pix_s = 24'h000000;
            default: bar_pix_s = 24'h000000;
        endcase
    end

    assign pix_s = pattern_en ? bar_pix_s : vid_pData;
`else
    logic unused_pattern_en_s;

    assign unused_pattern_en_s = pattern_en;
    assign pix_s               = vid_pData;
`endif

    // VDE delayed to line up with the two-stage channel pipelines
    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            vde_d1_r <= 1'b0;
            tx_vde   <= 1'b0;
        end else begin
            vde_d1_r <= vid_pVDE;
            tx_vde   <= vde_d1_r;
        end
    end

    tmds_channel_enc u_ch0 (
        .PixelClk (PixelClk),
        .aRst_n   (aRst_n),
        .data     (pix_s[15:8]),
        .vde      (vid_pVDE),
        .ctrl     ({vs_s, hs_s}),
        .sym      (tmds_ch0)
    );

    tmds_channel_enc u_ch1 (
        .PixelClk (PixelClk),
        .aRst_n   (aRst_n),
        .data     (pix_s[7:0]),
        .vde      (vid_pVDE),
        .ctrl     (2'b00),
        .sym      (tmds_ch1)
    );

    tmds_channel_enc u_ch2 (
        .PixelClk (PixelClk),
        .aRst_n   (aRst_n),
        .data     (pix_s[23:16]),
        .vde      (vid_pVDE),
        .ctrl     (2'b00),
        .sym      (tmds_ch2)
    );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed self-checking bench for dvi_tmds_encoder with a TMDS decoder model
// and an independent disparity tracker computed from the emitted symbols.
module tb_dvi_tmds_encoder;

    logic        PixelClk = 1'b0;
    logic        aRst_n   = 1'b0;
    logic [23:0] vid_pData  = 24'h000000;
    logic        vid_pVDE   = 1'b0;
    logic        vid_pHSync = 1'b0;
    logic        vid_pVSync = 1'b0;
    logic        pattern_en = 1'b0;
    logic [9:0]  tmds_ch0;
    logic [9:0]  tmds_ch1;
    logic [9:0]  tmds_ch2;
    logic        tx_vde;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          disp0    = 0;
    int          disp1    = 0;
    int          disp2    = 0;
    int          max_abs  = 0;
    logic [23:0] prev_d;
    logic        prev_v;
    logic [23:0] rnd_d;
    logic        rnd_v;

    always #5 PixelClk = ~PixelClk;

    dvi_tmds_encoder #(.SYNC_INV(1), .BAR_SHIFT(7)) dut (
        .PixelClk   (PixelClk),
        .aRst_n     (aRst_n),
        .vid_pData  (vid_pData),
        .vid_pVDE   (vid_pVDE),
        .vid_pHSync (vid_pHSync),
        .vid_pVSync (vid_pVSync),
        .pattern_en (pattern_en),
        .tmds_ch0   (tmds_ch0),
        .tmds_ch1   (tmds_ch1),
        .tmds_ch2   (tmds_ch2),
        .tx_vde     (tx_vde)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ones10(input logic [9:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            n += int'(s[i]);
        end
        return n;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic upd_disp();
        if (!tx_vde) begin
            disp0 = 0;
            disp1 = 0;
            disp2 = 0;
        end else begin
            disp0 += 2 * ones10(tmds_ch0) - 10;
            disp1 += 2 * ones10(tmds_ch1) - 10;
            disp2 += 2 * ones10(tmds_ch2) - 10;
        end
        if (iabs(disp0) > max_abs) max_abs = iabs(disp0);
        if (iabs(disp1) > max_abs) max_abs = iabs(disp1);
        if (iabs(disp2) > max_abs) max_abs = iabs(disp2);
    endtask

    // Apply one input sample; on return the outputs show the previous sample
    task automatic drive(input logic [23:0] d, input logic v, input logic vs, input logic hs);
        vid_pData  = d;
        vid_pVDE   = v;
        vid_pVSync = vs;
        vid_pHSync = hs;
        @(negedge PixelClk);
        upd_disp();
    endtask

    initial begin
        #12;
        check("rst_ch0", 32'(tmds_ch0), 32'h354);
        check("rst_ch1", 32'(tmds_ch1), 32'h354);
        check("rst_ch2", 32'(tmds_ch2), 32'h354);
        check("rst_vde", 32'(tx_vde), 32'h0);

        @(negedge PixelClk);
        aRst_n = 1'b1;
        drive(24'h000000, 1'b1, 1'b0, 1'b0);
        check("rel_ch1", 32'(tmds_ch1), 32'h354);
        check("rel_vde", 32'(tx_vde), 32'h0);

        drive(24'h000000, 1'b1, 1'b0, 1'b0);
        check("z1_ch0", 32'(tmds_ch0), 32'h100);
        check("z1_ch1", 32'(tmds_ch1), 32'h100);
        check("z1_ch2", 32'(tmds_ch2), 32'h100);
        check("z1_vde", 32'(tx_vde), 32'h1);
        check("z1_cnt", 32'(disp0), 32'(-8));
        drive(24'h000000, 1'b1, 1'b0, 1'b0);
        check("z2_ch0", 32'(tmds_ch0), 32'h3FF);
        check("z2_cnt", 32'(disp0), 32'(2));
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        check("z3_ch0", 32'(tmds_ch0), 32'h100);
        check("z3_ch2", 32'(tmds_ch2), 32'h100);
        check("z3_cnt", 32'(disp0), 32'(-6));

        drive(24'h00FF00, 1'b1, 1'b0, 1'b0);
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        check("ffb_ch0", 32'(tmds_ch0), 32'h200);
        check("ffb_ch1", 32'(tmds_ch1), 32'h100);
        check("ffb_ch2", 32'(tmds_ch2), 32'h100);
        check("ffb_cnt", 32'(disp0), 32'(-8));
        drive(24'hFF0000, 1'b1, 1'b0, 1'b0);
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        check("ffr_ch2", 32'(tmds_ch2), 32'h200);
        check("ffr_ch0", 32'(tmds_ch0), 32'h100);

        drive(24'h000000, 1'b0, 1'b1, 1'b1);
        drive(24'h000000, 1'b0, 1'b1, 1'b0);
        check("ctl11_ch0", 32'(tmds_ch0), 32'h354);
        check("ctl11_ch1", 32'(tmds_ch1), 32'h354);
        drive(24'h000000, 1'b0, 1'b0, 1'b1);
        check("ctl10_ch0", 32'(tmds_ch0), 32'h0AB);
        check("ctl10_ch1", 32'(tmds_ch1), 32'h354);
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        check("ctl01_ch0", 32'(tmds_ch0), 32'h154);
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        check("ctl00_ch0", 32'(tmds_ch0), 32'h2AB);
        check("ctl00_ch2", 32'(tmds_ch2), 32'h354);
        check("ctl00_vde", 32'(tx_vde), 32'h0);

        prev_d  = 24'h000000;
        prev_v  = 1'b0;
        max_abs = 0;
        for (int k = 0; k < 400; k++) begin
            rnd_d = 24'($urandom);
            rnd_v = ($urandom_range(0, 7) != 0);
            drive(rnd_d, rnd_v, 1'b0, 1'b0);
            check("rnd_vde", 32'(tx_vde), 32'(prev_v));
            if (prev_v) begin
                check("rnd_data", 32'({dec(tmds_ch2), dec(tmds_ch0), dec(tmds_ch1)}), 32'(prev_d));
            end
            prev_d = rnd_d;
            prev_v = rnd_v;
        end
        check("cnt_bound", 32'(max_abs <= 10), 32'h1);

        drive(24'h123456, 1'b1, 1'b0, 1'b0);
        drive(24'h0F0F0F, 1'b1, 1'b0, 1'b0);
        #2;
        aRst_n = 1'b0;
        #1;
        check("arst_ch0", 32'(tmds_ch0), 32'h354);
        check("arst_ch1", 32'(tmds_ch1), 32'h354);
        check("arst_ch2", 32'(tmds_ch2), 32'h354);
        check("arst_vde", 32'(tx_vde), 32'h0);
        disp0 = 0;
        @(negedge PixelClk);
        aRst_n = 1'b1;
        drive(24'h000000, 1'b1, 1'b0, 1'b0);
        check("post_ch0", 32'(tmds_ch0), 32'h354);
        drive(24'h000000, 1'b1, 1'b0, 1'b0);
        check("post_ch0_d", 32'(tmds_ch0), 32'h100);
        check("post_cnt", 32'(disp0), 32'(-8));

`ifdef TMDS_TEST_PATTERN_EN
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        pattern_en = 1'b1;
        for (int p = 0; p < 1025; p++) begin
            drive(24'h000000, (p < 1024), 1'b0, 1'b0);
            if (p == 1 || p == 128 || p == 897 || p == 1024) begin
                check("bar_r", 32'(dec(tmds_ch2)), (p < 200) ? 32'hFF : 32'h00);
            end
        end
        pattern_en = 1'b0;
`else
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        pattern_en = 1'b1;
        drive(24'hFF0000, 1'b1, 1'b0, 1'b0);
        drive(24'h000000, 1'b0, 1'b0, 1'b0);
        check("pat_off_ch2", 32'(tmds_ch2), 32'h200);
        check("pat_off_ch0", 32'(tmds_ch0), 32'h100);
        pattern_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
